// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int ENTRY_W = 2 * XLEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with show-ahead read and synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, memory requests, prefetch buffering, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to the output when the FIFO is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_read,
    input  logic [31:0]       i_imem_data,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_pc,
    input  logic              i_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = CNT_W + 1;

    logic [XLEN-1:0]    pc_reg;
    logic               inflight_reg;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic               fifo_push;
    logic               fifo_pop;
    logic               resp_valid;
    logic               bypass;
    logic               pop;
    logic [OUT_W-1:0]   outstanding;
    fetch_entry_t       resp;
    fetch_entry_t       head;
    logic               unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    // pc has already advanced past the outstanding request, so step back one word.
    assign resp.pc      = pc_reg - PC_STEP;
    assign resp.instr   = i_imem_data;
    assign resp_valid   = inflight_reg && !i_redirect;
    assign head         = fetch_entry_t'(fifo_rd_data);
    assign fifo_wr_data = resp;
    assign pop          = o_valid && i_ready;

`ifdef FETCH_BYPASS_EN
    assign bypass    = resp_valid && fifo_empty;
    assign fifo_push = resp_valid && !(bypass && i_ready);
`else
    assign bypass    = 1'b0;
    assign fifo_push = resp_valid;
`endif

    assign fifo_pop    = pop && !bypass;
    assign outstanding = OUT_W'(fifo_count) + OUT_W'(inflight_reg);
    assign o_imem_read = !i_reset && !i_redirect
                         && ((outstanding < OUT_W'(DEPTH)) || pop);
    assign o_imem_addr = pc_reg[ADDR_W-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
        end else if (i_redirect) begin
            pc_reg       <= {i_redirect_pc[31:2], 2'b00};
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= o_imem_read;
            if (o_imem_read) begin
                pc_reg <= pc_reg + PC_STEP;
            end
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_pc    = '0;
        o_instr = '0;
        if (bypass) begin
            o_valid = 1'b1;
            o_pc    = resp.pc;
            o_instr = resp.instr;
        end else if (!fifo_empty) begin
            o_valid = 1'b1;
            o_pc    = head.pc;
            o_instr = head.instr;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .flush   (i_redirect),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream scoreboard.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] RPC    = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_redirect = 1'b0;
    logic [31:0]       i_redirect_pc = '0;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              o_imem_read;
    logic [31:0]       imem_data = '0;
    logic              o_valid;
    logic [31:0]       o_instr;
    logic [31:0]       o_pc;
    logic              i_ready = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pops = 0;
    int          outstanding = 0;
    logic [31:0] exp_pc = '0;
    logic        sb_en = 1'b0;

    fetch_unit #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .RESET_PC(RPC)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_addr  (o_imem_addr),
        .o_imem_read  (o_imem_read),
        .i_imem_data  (imem_data),
        .o_valid      (o_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .i_ready      (i_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    // Registered instruction memory: data valid one cycle after the request.
    always @(posedge clk) begin
        if (o_imem_read) imem_data <= mem_word(o_imem_addr);
    end

    // Stream scoreboard: the accepted words must be exactly consecutive PCs, restarting at each redirect target.
    always @(negedge clk) begin
        if (sb_en) begin
            if (o_valid !== 1'b1) begin
                n_cmp++;
                if (o_pc !== 32'h0 || o_instr !== 32'h0)
                    $display("FAIL idle_zero: got pc=%h instr=%h expected 0/0", o_pc, o_instr);
                    if (o_pc !== 32'h0 || o_instr !== 32'h0) n_bad++;
            end else if (i_ready) begin
                n_cmp++;
                if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc[7:0])) begin
                    n_bad++;
                    $display("FAIL stream_order: got pc=%h instr=%h expected pc=%h instr=%h",
                             o_pc, o_instr, exp_pc, mem_word(exp_pc[7:0]));
                end
                exp_pc = exp_pc + 32'd4;
                n_pops++;
                if (!i_redirect) outstanding--;
            end
            if (i_redirect) begin
                n_cmp++;
                if (o_imem_read !== 1'b0) begin
                    n_bad++;
                    $display("FAIL read_in_redirect: got %b expected 0", o_imem_read);
                end
                exp_pc = {i_redirect_pc[31:2], 2'b00};
                outstanding = 0;
            end else begin
                if (o_imem_read === 1'b1) outstanding++;
                n_cmp++;
                if (outstanding > DEPTH) begin
                    n_bad++;
                    $display("FAIL outstanding_bound: got %0d expected <= %0d", outstanding, DEPTH);
                end
            end
        end
    end

    task automatic apply_reset(input logic rdy);
        sb_en = 1'b0;
        i_reset = 1'b1;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        exp_pc = RPC;
        outstanding = 0;
        i_reset = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_reset();
        sb_en = 1'b0;
        i_reset = 1'b1;
        i_ready = 1'b1;
        i_redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_imem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %b expected 0", o_imem_read); end
        n_cmp++; if (o_imem_addr !== RPC[ADDR_W-1:0]) begin n_bad++; $display("FAIL reset_addr: got %h expected %h", o_imem_addr, RPC[ADDR_W-1:0]); end
        n_cmp++; if (o_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h expected 0", o_instr); end
        n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
        @(posedge clk);
        #1;
        exp_pc = RPC;
        outstanding = 0;
        i_reset = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_imem_read !== 1'b1 || o_imem_addr !== RPC[ADDR_W-1:0]) begin
            n_bad++;
            $display("FAIL cycle0_request: got read=%b addr=%h expected 1/%h", o_imem_read, o_imem_addr, RPC[ADDR_W-1:0]);
        end
        $display("test_reset done: %0d compared / %0d bad so far", n_cmp, n_bad);
    endtask

    task automatic test_stream();
        int first = -1;
        apply_reset(1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (first < 0 && o_valid === 1'b1) first = c;
            if (c > LAT) begin
                n_cmp++;
                if (o_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_throughput: cycle %0d got valid=%b expected 1", c, o_valid);
                end
            end
        end
        n_cmp++;
        if (first != LAT) begin
            n_bad++;
            $display("FAIL first_latency: got cycle %0d expected %0d", first, LAT);
        end
        $display("test_stream done: first valid in cycle %0d", first);
    endtask

    task automatic test_backpressure();
        int reads = 0;
        apply_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_imem_read === 1'b1) reads++;
        end
        n_cmp++;
        if (reads != DEPTH) begin n_bad++; $display("FAIL bp_reads: got %0d expected %0d", reads, DEPTH); end
        n_cmp++;
        if (o_imem_read !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got read=%b expected 0", o_imem_read); end
        @(posedge clk);
        #1 i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release_gap: cycle %0d got valid=%b expected 1", c, o_valid); end
        end
        $display("test_backpressure done: %0d reads while stalled", reads);
    endtask

    task automatic test_redirect_buffered();
        apply_reset(1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h40;
        @(negedge clk);
        n_cmp++;
        if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rd_buffered: got valid=%b expected 1", o_valid); end
        @(posedge clk);
        #1;
        i_redirect = 1'b0;
        i_ready = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (o_imem_read !== 1'b1 || o_imem_addr !== 8'h40) begin
                    n_bad++;
                    $display("FAIL rd_target_req: got read=%b addr=%h expected 1/40", o_imem_read, o_imem_addr);
                end
            end
            if (k <= LAT) begin
                n_cmp++;
                if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale: N+%0d got valid=%b pc=%h expected 0", k, o_valid, o_pc); end
            end else begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_pc !== 32'h40) begin
                    n_bad++;
                    $display("FAIL rd_target_valid: N+%0d got valid=%b pc=%h expected 1/40", k, o_valid, o_pc);
                end
            end
        end
        repeat (6) @(negedge clk);
        $display("test_redirect_buffered done");
    endtask

    task automatic test_redirect_pop();
        int seen = 0;
        apply_reset(1'b1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h43;
        @(negedge clk);
        n_cmp++;
        if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rp_pop_valid: got valid=%b expected 1", o_valid); end
        @(posedge clk);
        #1 i_redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_imem_read !== 1'b1 || o_imem_addr !== 8'h40) begin
            n_bad++;
            $display("FAIL rp_aligned_req: got read=%b addr=%h expected 1/40", o_imem_read, o_imem_addr);
        end
        for (int k = 0; k < 4 && seen == 0; k++) begin
            if (k > 0) @(negedge clk);
            if (o_valid === 1'b1) begin
                seen = 1;
                n_cmp++;
                if (o_pc !== 32'h40) begin n_bad++; $display("FAIL rp_first_pc: got %h expected 00000040", o_pc); end
            end
        end
        n_cmp++;
        if (seen == 0) begin n_bad++; $display("FAIL rp_timeout: got no valid expected pc 00000040"); end
        repeat (6) @(negedge clk);
        $display("test_redirect_pop done");
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        sb_en = 1'b0;
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_imem_read !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b read=%b instr=%h pc=%h expected all 0",
                     o_valid, o_imem_read, o_instr, o_pc);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_pc = RPC;
        outstanding = 0;
        i_reset = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_imem_read !== 1'b1 || o_imem_addr !== RPC[ADDR_W-1:0]) begin
            n_bad++;
            $display("FAIL async_restart: got read=%b addr=%h expected 1/%h", o_imem_read, o_imem_addr, RPC[ADDR_W-1:0]);
        end
        repeat (8) @(negedge clk);
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int pops_before;
        apply_reset(1'b1);
        pops_before = n_pops;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            i_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                i_redirect = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    i_redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else
                    i_redirect_pc = $urandom;
            end else begin
                i_redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1 i_redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (n_pops - pops_before < 500) begin
            n_bad++;
            $display("FAIL random_progress: got %0d pops expected >= 500", n_pops - pops_before);
        end
        $display("test_random done: %0d words delivered", n_pops - pops_before);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_buffered();
        test_redirect_pop();
        test_async_reset();
        test_random();
        sb_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
